// File: rtl/regfile_datapath_pkg.sv
// Shared encodings for the register-file datapath: immediate formats and the
// width of the upper-immediate prefix register.
package regfile_datapath_pkg;

    localparam int UI_W = 10;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_2RI  = 3'd1,
        IMM_RI   = 3'd2,
        IMM_UJ   = 3'd3,
        IMM_L    = 3'd4
    } imm_type_e;

endpackage

// File: rtl/regfile_datapath_if.sv
// Bus bundle between the datapath and its controller: read/write ports,
// immediate inputs and the latched outputs.
interface regfile_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] input_reg_readA_address;
    logic [ADDR_W-1:0] input_reg_readB_address;
    logic              input_reg_write;
    logic [ADDR_W-1:0] input_reg_write_address;
    logic [DATA_W-1:0] input_ALUOut;
    logic [DATA_W-1:0] input_MDR;
    logic              memToReg;
    logic [15:0]       input_instr;
    logic [2:0]        input_imm_type;
    logic              input_latch_en;
    logic [DATA_W-1:0] output_reg_A;
    logic [DATA_W-1:0] output_reg_B;
    logic [DATA_W-1:0] output_imm;
    logic              output_ui_valid;

    modport master (
        output input_reg_readA_address, input_reg_readB_address,
        output input_reg_write, input_reg_write_address,
        output input_ALUOut, input_MDR, memToReg,
        output input_instr, input_imm_type, input_latch_en,
        input  output_reg_A, output_reg_B, output_imm, output_ui_valid
    );

    modport slave (
        input  input_reg_readA_address, input_reg_readB_address,
        input  input_reg_write, input_reg_write_address,
        input  input_ALUOut, input_MDR, memToReg,
        input  input_instr, input_imm_type, input_latch_en,
        output output_reg_A, output_reg_B, output_imm, output_ui_valid
    );
endinterface

// File: rtl/regfile_datapath_imm_gen.sv
// Immediate extraction plus the upper-immediate (L) prefix register that
// extends the next 2RI immediate.
module imm_gen
    import regfile_datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_instr,
    input  logic [2:0]        i_imm_type,
    input  logic              i_latch_en,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_ui_valid
);

    logic [DATA_W-1:0] r_imm;
    logic [UI_W-1:0]   r_ui;
    logic              r_ui_valid;

    logic [DATA_W-1:0] w_imm_next;
    logic [UI_W-1:0]   w_ui_next;
    logic              w_ui_valid_next;
    logic signed [15:0] w_prefixed;
    logic signed [5:0]  w_f2ri;
    logic signed [7:0]  w_fri;
    logic signed [9:0]  w_fuj;
    logic              w_unused_instr;

    assign w_prefixed     = {r_ui, i_instr[15:10]};
    assign w_f2ri         = i_instr[15:10];
    assign w_fri          = i_instr[15:8];
    assign w_fuj          = i_instr[15:6];
    assign w_unused_instr = ^i_instr[5:0];

    always_comb begin
        w_imm_next      = '0;
        w_ui_next       = r_ui;
        w_ui_valid_next = r_ui_valid;
        case (i_imm_type)
            IMM_2RI: begin
                // A pending L prefix is consumed by exactly one 2RI
                if (r_ui_valid) begin
                    w_imm_next      = DATA_W'(w_prefixed);
                    w_ui_valid_next = 1'b0;
                end else begin
                    w_imm_next = DATA_W'(w_f2ri);
                end
            end
            IMM_RI: w_imm_next = DATA_W'(w_fri);
            IMM_UJ: w_imm_next = DATA_W'(w_fuj);
            IMM_L: begin
                w_ui_next       = i_instr[15:6];
                w_ui_valid_next = 1'b1;
            end
            default: w_imm_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imm      <= '0;
            r_ui       <= '0;
            r_ui_valid <= 1'b0;
        end else if (i_latch_en) begin
            r_imm      <= w_imm_next;
            r_ui       <= w_ui_next;
            r_ui_valid <= w_ui_valid_next;
        end
    end

    assign o_imm      = r_imm;
    assign o_ui_valid = r_ui_valid;

endmodule

// File: rtl/regfile_datapath.sv
// Register file with MDR/ALU write mux, optional r0-hardwired-zero and
// write-to-read forwarding into the latched A/B operand registers.
module regfile_datapath
    import regfile_datapath_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    regfile_datapath_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_reg_a;
    logic [DATA_W-1:0] r_reg_b;

    logic [DATA_W-1:0] w_wdata;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_wdata = bus.memToReg ? bus.input_MDR : bus.input_ALUOut;
    assign w_wr_en = bus.input_reg_write &&
                     !((ZERO_R0 != 0) && (bus.input_reg_write_address == '0));

    // w_wr_en already excludes r0 when it is hardwired, so forwarding never leaks into r0
    always_comb begin
        w_rd_a = r_regs[bus.input_reg_readA_address];
        if ((BYPASS != 0) && w_wr_en &&
            (bus.input_reg_readA_address == bus.input_reg_write_address))
            w_rd_a = w_wdata;
        if ((ZERO_R0 != 0) && (bus.input_reg_readA_address == '0))
            w_rd_a = '0;
    end

    always_comb begin
        w_rd_b = r_regs[bus.input_reg_readB_address];
        if ((BYPASS != 0) && w_wr_en &&
            (bus.input_reg_readB_address == bus.input_reg_write_address))
            w_rd_b = w_wdata;
        if ((ZERO_R0 != 0) && (bus.input_reg_readB_address == '0))
            w_rd_b = '0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.input_reg_write_address] <= w_wdata;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
        end else if (bus.input_latch_en) begin
            r_reg_a <= w_rd_a;
            r_reg_b <= w_rd_b;
        end
    end

    assign bus.output_reg_A = r_reg_a;
    assign bus.output_reg_B = r_reg_b;

    imm_gen #(
        .DATA_W(DATA_W)
    ) u_imm_gen (
        .clk       (CLK),
        .rst       (Reset),
        .i_instr   (bus.input_instr),
        .i_imm_type(bus.input_imm_type),
        .i_latch_en(bus.input_latch_en),
        .o_imm     (bus.output_imm),
        .o_ui_valid(bus.output_ui_valid)
    );

endmodule

// File: tb/tb_regfile_datapath.sv
// Directed bench: three datapath variants (default, no-bypass, zero-r0) driven
// by one stimulus stream, each output checked against hand-computed values.
module tb_regfile_datapath;

    logic        CLK;
    logic        Reset;
    logic [2:0]  ra, rb, wa;
    logic        wr, m2r, latch;
    logic [15:0] alu, mdr, instr;
    logic [2:0]  itype;

    int checks   = 0;
    int failures = 0;

    regfile_datapath_if #(.DATA_W(16), .ADDR_W(3)) if_d  ();
    regfile_datapath_if #(.DATA_W(16), .ADDR_W(3)) if_nb ();
    regfile_datapath_if #(.DATA_W(16), .ADDR_W(3)) if_z  ();

    assign if_d.input_reg_readA_address  = ra;  assign if_nb.input_reg_readA_address  = ra;  assign if_z.input_reg_readA_address  = ra;
    assign if_d.input_reg_readB_address  = rb;  assign if_nb.input_reg_readB_address  = rb;  assign if_z.input_reg_readB_address  = rb;
    assign if_d.input_reg_write          = wr;  assign if_nb.input_reg_write          = wr;  assign if_z.input_reg_write          = wr;
    assign if_d.input_reg_write_address  = wa;  assign if_nb.input_reg_write_address  = wa;  assign if_z.input_reg_write_address  = wa;
    assign if_d.input_ALUOut             = alu; assign if_nb.input_ALUOut             = alu; assign if_z.input_ALUOut             = alu;
    assign if_d.input_MDR                = mdr; assign if_nb.input_MDR                = mdr; assign if_z.input_MDR                = mdr;
    assign if_d.memToReg                 = m2r; assign if_nb.memToReg                 = m2r; assign if_z.memToReg                 = m2r;
    assign if_d.input_instr              = instr; assign if_nb.input_instr            = instr; assign if_z.input_instr            = instr;
    assign if_d.input_imm_type           = itype; assign if_nb.input_imm_type         = itype; assign if_z.input_imm_type         = itype;
    assign if_d.input_latch_en           = latch; assign if_nb.input_latch_en         = latch; assign if_z.input_latch_en         = latch;

    regfile_datapath #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1))
        dut    (.CLK(CLK), .Reset(Reset), .bus(if_d));
    regfile_datapath #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0), .BYPASS(0))
        dut_nb (.CLK(CLK), .Reset(Reset), .bus(if_nb));
    regfile_datapath #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1))
        dut_z  (.CLK(CLK), .Reset(Reset), .bus(if_z));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr = 0; m2r = 0; latch = 0; itype = 3'd0; instr = 16'h0;
    endtask

    initial begin
        Reset = 1'b1;
        ra = 0; rb = 0; wa = 0; alu = 0; mdr = 0;
        idle();
        #12;
        chk("rst_A",     if_d.output_reg_A, 16'h0000);
        chk("rst_B",     if_d.output_reg_B, 16'h0000);
        chk("rst_imm",   if_d.output_imm,   16'h0000);
        chk("rst_uiv",   {15'd0, if_d.output_ui_valid}, 16'h0000);
        @(negedge CLK);
        Reset = 1'b0;

        // r0 = 1, r1 = 5 through MDR
        wr = 1; m2r = 1; wa = 0; mdr = 16'h0001; step();
        wa = 1; mdr = 16'h0005; step();
        idle(); latch = 1; ra = 0; rb = 1; step();
        chk("lat_A",     if_d.output_reg_A,  16'h0001);
        chk("lat_B",     if_d.output_reg_B,  16'h0005);
        chk("lat_nb_A",  if_nb.output_reg_A, 16'h0001);
        chk("lat_z_A",   if_z.output_reg_A,  16'h0000);
        chk("lat_z_B",   if_z.output_reg_B,  16'h0005);

        // no latch: outputs hold
        idle(); ra = 1; rb = 0; step();
        chk("hold_A",    if_d.output_reg_A, 16'h0001);
        chk("hold_B",    if_d.output_reg_B, 16'h0005);

        // write r2 from ALUOut with same-cycle latch
        wr = 1; m2r = 0; wa = 2; alu = 16'h1234; mdr = 16'hAAAA; latch = 1; ra = 2; rb = 1; step();
        chk("byp_A",     if_d.output_reg_A,  16'h1234);
        chk("byp_nb_A",  if_nb.output_reg_A, 16'h0000);
        chk("byp_z_A",   if_z.output_reg_A,  16'h1234);
        chk("byp_B",     if_d.output_reg_B,  16'h0005);
        idle(); latch = 1; ra = 2; rb = 2; step();
        chk("r2_nb_A",   if_nb.output_reg_A, 16'h1234);
        chk("r2_B",      if_d.output_reg_B,  16'h1234);

        // r0 write of 0xBEEF
        wr = 1; m2r = 0; wa = 0; alu = 16'hBEEF; latch = 1; ra = 0; rb = 0; step();
        chk("r0w_A",     if_d.output_reg_A,  16'hBEEF);
        chk("r0w_nb_A",  if_nb.output_reg_A, 16'h0001);
        chk("r0w_z_A",   if_z.output_reg_A,  16'h0000);
        idle(); latch = 1; ra = 0; rb = 2; step();
        chk("r0r_A",     if_d.output_reg_A,  16'hBEEF);
        chk("r0r_z_A",   if_z.output_reg_A,  16'h0000);
        chk("r0r_z_B",   if_z.output_reg_B,  16'h1234);

        // immediate formats
        latch = 1; itype = 3'd1; instr = 16'hFC00; step();
        chk("imm_2ri",   if_d.output_imm, 16'hFFFF);
        itype = 3'd2; instr = 16'h0100; step();
        chk("imm_ri",    if_d.output_imm, 16'h0001);
        itype = 3'd2; instr = 16'h8000; step();
        chk("imm_ri_neg", if_d.output_imm, 16'hFF80);
        itype = 3'd3; instr = 16'h0340; step();
        chk("imm_uj",    if_d.output_imm, 16'h000D);
        itype = 3'd6; instr = 16'hFFFF; step();
        chk("imm_rsvd",  if_d.output_imm, 16'h0000);
        chk("uiv_rsvd",  {15'd0, if_d.output_ui_valid}, 16'h0000);

        // UI prefix sequence
        itype = 3'd4; instr = 16'h0040; step();
        chk("imm_l",     if_d.output_imm, 16'h0000);
        chk("uiv_l",     {15'd0, if_d.output_ui_valid}, 16'h0001);
        itype = 3'd2; instr = 16'h0100; step();
        chk("ri_ui_imm", if_d.output_imm, 16'h0001);
        chk("ri_uiv",    {15'd0, if_d.output_ui_valid}, 16'h0001);
        itype = 3'd0; instr = 16'hFFFF; step();
        chk("none_imm",  if_d.output_imm, 16'h0000);
        chk("none_uiv",  {15'd0, if_d.output_ui_valid}, 16'h0001);
        itype = 3'd1; instr = 16'h0400; step();
        chk("pfx_imm",   if_d.output_imm, 16'h0041);
        chk("pfx_uiv",   {15'd0, if_d.output_ui_valid}, 16'h0000);
        itype = 3'd1; instr = 16'h0400; step();
        chk("2ri_after", if_d.output_imm, 16'h0001);

        // L overwrite, negative prefix, and L without latch_en
        itype = 3'd4; instr = 16'h0080; step();
        itype = 3'd4; instr = 16'hFFC0; step();
        chk("l_ovr_uiv", {15'd0, if_d.output_ui_valid}, 16'h0001);
        itype = 3'd1; instr = 16'h0000; step();
        chk("pfx_neg",   if_d.output_imm, 16'hFFC0);
        latch = 0; itype = 3'd4; instr = 16'h0040; step();
        chk("l_nolat",   {15'd0, if_d.output_ui_valid}, 16'h0000);
        chk("imm_nolat", if_d.output_imm, 16'hFFC0);

        // set up non-zero state, then async reset between edges
        latch = 1; itype = 3'd4; instr = 16'h0040; ra = 2; rb = 1; step();
        idle();
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_A",    if_d.output_reg_A, 16'h0000);
        chk("arst_B",    if_d.output_reg_B, 16'h0000);
        chk("arst_uiv",  {15'd0, if_d.output_ui_valid}, 16'h0000);
        chk("arst_nb_A", if_nb.output_reg_A, 16'h0000);

        // write attempted while reset is held is lost
        wr = 1; m2r = 0; wa = 3; alu = 16'h5555; step();
        idle();
        @(negedge CLK);
        Reset = 1'b0;
        latch = 1; ra = 2; rb = 3; step();
        chk("post_A",    if_d.output_reg_A, 16'h0000);
        chk("post_B",    if_d.output_reg_B, 16'h0000);
        ra = 1; rb = 0; step();
        chk("post_r1",   if_d.output_reg_A, 16'h0000);
        chk("post_r0",   if_d.output_reg_B, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
